mfm_data_separator: RTL
=======================

# mfm_data_separator

Digital data separator for the floppy read path. Recovers the MFM bit-cell timing from the drive's raw read-data pulses, sampled on the 16 MHz system clock. Emits the raw MFM half-cell stream, detects the A1 sync mark (MFM word 0x4489), and delivers byte-aligned decoded data to the FDC-side logic. It is the receive-side counterpart of the clock divider, recovering timing from the media instead of generating it.

## Interface
Parameters:
- HALF_CELL, 32, clocks per MFM half-cell (16 MHz, DD 250 kbps → 2 µs); even, ≥ 16
- MAX_ADJ, 2, max per-window length correction in clocks
- SYNC_WORD, 16'h4489, raw MFM pattern of the A1 missing-clock mark

Ports:
- clk  in  1  16 MHz system clock
- rst  in  1  asynchronous, active-low reset
- enable  in  1  1 = separator running; 0 = synchronous clear of all state
- rd_data_n  in  1  raw drive read data, asynchronous, active-low pulses
- raw_bit  out  1  value of the half-cell just closed
- raw_strobe  out  1  one-cycle pulse at each half-cell end
- data_byte  out  8  decoded byte, MSB first
- byte_valid  out  1  one-cycle pulse, data_byte valid
- sync_found  out  1  one-cycle pulse on SYNC_WORD match
- in_sync  out  1  level, byte alignment established

## Operation
- Input: rd_data_n passes through 2 synchronizer flops plus 1 history flop. The pulse event is the falling edge (history=1, sync2=0). Pin-to-event latency is 3 clocks.
- Window counter cnt runs 0..len-1, and len is fixed per window.
  - At the start of each window, len = HALF_CELL.
  - On the first event in a window at cnt = p, compute e = p − HALF_CELL/2. Set len = HALF_CELL + clamp(e, −MAX_ADJ, +MAX_ADJ) for that window.
  - Later events in the same window are ignored for phase and only set the seen flag.
- At cnt == len−1:
  - raw_strobe = 1.
  - raw_bit = seen flag OR event in this cycle.
  - cnt → 0 and the seen flag clears.
  - An event in the same cycle counts for the closing window, not the next.
- Shift register sr[15:0] takes raw_bit on each strobe.
- Sync: a match of SYNC_WORD against sr, compared in the cycle after the strobe, causes:
  - sync_found = 1.
  - byte_valid = 1 with data_byte = 8'hA1.
  - in_sync = 1.
  - The pair and bit counters clear. The next raw bit is a clock bit.
- Matches are honoured whether or not in_sync is already 1, so consecutive A1 marks realign each time.
- Decoding while in_sync = 1:
  - Raw bits alternate clock, data.
  - Data bits shift MSB-first into the byte.
  - After the 8th data bit, byte_valid pulses and the bit counter wraps.
- Loss of sync happens on an MFM violation in sr: two consecutive 1s, or four consecutive 0s. The response is in_sync → 0, bit and pair counters clear, and no byte_valid until the next sync match. A violation and a sync match in the same cycle resolve as sync match.
- enable = 0 clears counters, the synchronizer history, sr, and all outputs to 0 on the next edge. Input pulses are ignored.

## Timing
- rst low clears all flops immediately: every output 0, cnt = 0, len = HALF_CELL, sr = 0.
- raw_strobe is one cycle long, spaced len clocks apart, with len ∈ [HALF_CELL−MAX_ADJ, HALF_CELL+MAX_ADJ].
- sync_found and its byte_valid are asserted exactly 1 cycle after the raw_strobe that completed the match.
- byte_valid for a data byte is asserted 1 cycle after the strobe of its 16th raw bit (8th data bit).
- data_byte holds until the next byte_valid.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert rst low mid-window while in_sync = 1 → all outputs 0 in the same cycle; the first raw_strobe comes 32 clocks after rst rises with enable = 1.
- Nominal lock:
  - Stimulus: 1-clock low pulse on rd_data_n every 64 clocks, centred (event at cnt = 16).
  - Required: raw_strobe every 32 clocks, raw_bit alternating 1,0, len constantly 32.
- Phase tracking:
  - Stimulus: the same pulse train shifted 5 clocks late.
  - Required: first corrected window len = 34. Error then steps 3 → 1 → 0 with len 34, 33, then 32. No raw_bit is lost.
- Sync and bytes:
  - Stimulus: MFM stream of 0x4489 ×3, then FE.
  - Required: 3 sync_found pulses, byte_valid sequence A1, A1, A1, FE, in_sync = 1.
- Violation: after sync, inject raw bits 1,1 → in_sync = 0 one cycle after the second strobe, and no further byte_valid until the next 0x4489.
- Enable: drop enable mid-byte → all outputs 0 next cycle. Re-enable with a sync stream → relock and A1 decoded.

Source files
------------

// File: rtl/mfm_data_separator.sv
// MFM data separator: recovers half-cell timing from raw read pulses, finds the
// 0x4489 A1 mark and shifts out byte-aligned decoded data.
module mfm_data_separator #(
    parameter int          HALF_CELL = 32,
    parameter int          MAX_ADJ   = 2,
    parameter logic [15:0] SYNC_WORD = 16'h4489
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       rd_data_n,
    output logic       raw_bit,
    output logic       raw_strobe,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       sync_found,
    output logic       in_sync
);

    localparam int CW = $clog2(HALF_CELL + MAX_ADJ + 1);
    localparam logic signed [CW+1:0] MID_S  = (CW+2)'(HALF_CELL / 2);
    localparam logic signed [CW+1:0] ADJ_S  = (CW+2)'(MAX_ADJ);
    localparam logic signed [CW+1:0] CELL_S = (CW+2)'(HALF_CELL);

    // Window length for a first pulse seen at count p, phase error saturated.
    function automatic logic [CW-1:0] adj_len(input logic [CW-1:0] p);
        logic signed [CW+1:0] e;
        e = $signed({2'b00, p}) - MID_S;
        if (e > ADJ_S)
            e = ADJ_S;
        else if (e < -ADJ_S)
            e = -ADJ_S;
        return CW'(CELL_S + e);
    endfunction

    logic          sync1_p0, sync2_p0, hist_p0;
    logic          ev_p0;
    logic [CW-1:0] cnt_p1, len_p1;
    logic          seen_p1;
    logic          last_p1;
    logic [15:0]   sr_p1;
    logic          match_p2, viol_p2;
    logic          phase_p2;
    logic [2:0]    bit_cnt_p2;
    logic [6:0]    byte_sh_p2;

    // Stage 0: synchronizer and falling-edge detect
    assign ev_p0   = hist_p0 & ~sync2_p0;

    // Stage 1: half-cell window tracking
    assign last_p1 = (cnt_p1 == len_p1 - CW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_p0   <= 1'b0;
            sync2_p0   <= 1'b0;
            hist_p0    <= 1'b0;
            cnt_p1     <= '0;
            len_p1     <= CW'(HALF_CELL);
            seen_p1    <= 1'b0;
            sr_p1      <= '0;
            raw_bit    <= 1'b0;
            raw_strobe <= 1'b0;
        end else if (!enable) begin
            sync1_p0   <= 1'b0;
            sync2_p0   <= 1'b0;
            hist_p0    <= 1'b0;
            cnt_p1     <= '0;
            len_p1     <= CW'(HALF_CELL);
            seen_p1    <= 1'b0;
            sr_p1      <= '0;
            raw_bit    <= 1'b0;
            raw_strobe <= 1'b0;
        end else begin
            sync1_p0   <= rd_data_n;
            sync2_p0   <= sync1_p0;
            hist_p0    <= sync2_p0;
            raw_strobe <= 1'b0;
            if (last_p1) begin
                // A pulse landing on the closing count belongs to this window.
                cnt_p1     <= '0;
                len_p1     <= CW'(HALF_CELL);
                seen_p1    <= 1'b0;
                raw_strobe <= 1'b1;
                raw_bit    <= seen_p1 | ev_p0;
                sr_p1      <= {sr_p1[14:0], seen_p1 | ev_p0};
            end else begin
                cnt_p1 <= cnt_p1 + CW'(1);
                if (ev_p0) begin
                    seen_p1 <= 1'b1;
                    if (!seen_p1)
                        len_p1 <= adj_len(cnt_p1);
                end
            end
        end
    end

    // Stage 2: sync detection and clock/data decode, evaluated the cycle after each strobe
    assign match_p2 = raw_strobe && (sr_p1 == SYNC_WORD);
    assign viol_p2  = (sr_p1[1:0] == 2'b11) || (sr_p1[3:0] == 4'b0000);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_p2   <= 1'b0;
            bit_cnt_p2 <= '0;
            byte_sh_p2 <= '0;
            data_byte  <= '0;
            byte_valid <= 1'b0;
            sync_found <= 1'b0;
            in_sync    <= 1'b0;
        end else if (!enable) begin
            phase_p2   <= 1'b0;
            bit_cnt_p2 <= '0;
            byte_sh_p2 <= '0;
            data_byte  <= '0;
            byte_valid <= 1'b0;
            sync_found <= 1'b0;
            in_sync    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            sync_found <= 1'b0;
            if (match_p2) begin
                sync_found <= 1'b1;
                byte_valid <= 1'b1;
                data_byte  <= 8'hA1;
                in_sync    <= 1'b1;
                phase_p2   <= 1'b0;
                bit_cnt_p2 <= '0;
            end else if (raw_strobe && in_sync) begin
                if (viol_p2) begin
                    in_sync    <= 1'b0;
                    phase_p2   <= 1'b0;
                    bit_cnt_p2 <= '0;
                end else if (!phase_p2) begin
                    phase_p2 <= 1'b1;
                end else begin
                    phase_p2   <= 1'b0;
                    byte_sh_p2 <= {byte_sh_p2[5:0], sr_p1[0]};
                    bit_cnt_p2 <= bit_cnt_p2 + 3'd1;
                    if (bit_cnt_p2 == 3'd7) begin
                        data_byte  <= {byte_sh_p2, sr_p1[0]};
                        byte_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
